uart_alu_cmd: RTL and testbench

UART_ALU_CMD -- requirements
Module: uart_alu_cmd

---
 rtl/uart_alu_pkg.sv | 37 +++
 rtl/uart_alu_cmd_if.sv | 32 +++
 rtl/uart_alu_timeout.sv | 33 +++
 rtl/uart_alu_cmd.sv | 135 +++++++++++++
 tb/tb_uart_alu_cmd.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU command block.
// Holds the default operand/opcode widths, the eight opcode values,
// the command FSM state encoding and an opcode-set membership helper.
package uart_alu_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_OP_W   = 6;

  // Opcode values (MIPS funct-style encoding)
  localparam int unsigned OP_ADD = 32'h20;
  localparam int unsigned OP_SUB = 32'h22;
  localparam int unsigned OP_AND = 32'h24;
  localparam int unsigned OP_OR  = 32'h25;
  localparam int unsigned OP_XOR = 32'h26;
  localparam int unsigned OP_NOR = 32'h27;
  localparam int unsigned OP_SRL = 32'h02;
  localparam int unsigned OP_SRA = 32'h03;

  typedef enum logic [2:0] {
    ST_OP,
    ST_A,
    ST_B,
    ST_CALC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  // True when the opcode field names one of the supported operations
  function automatic logic is_valid_op(input int unsigned op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_cmd_if.sv
// Bundle between the command block and its UART receiver/transmitter and ALU.
// slave : the command block (consumes RX/TX strobes and ALU result).
// master: the surroundings (UART, ALU) that drive those strobes.
interface uart_alu_cmd_if
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OP_W   = DEF_OP_W
);

  logic              i_rx_done;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_tx_done;
  logic [DATA_W-1:0] i_alu_result;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [OP_W-1:0]   o_alu_op;
  logic              o_tx_start;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_err;

  modport slave (
    input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_err
  );

  modport master (
    output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_err
  );

endinterface

// File: rtl/uart_alu_timeout.sv
// Inter-byte timeout counter.
// Ports: i_clk, i_reset (async, active-low), i_clr (restart from 0),
// i_en (count this cycle), o_tc_c (combinational terminal count,
// high while the count equals TIMEOUT_CLKS-1).
module uart_alu_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 26040
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_tc_c = (cnt_q == TC_VAL);

  // Clear wins over count; saturate at terminal so the count never wraps
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && !o_tc_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_alu_cmd.sv
// UART command front-end for an ALU.
// Receives opcode, operand A and operand B bytes, presents them to an
// external combinational ALU, captures the result and hands it to the
// UART transmitter. Bad opcodes, stray bytes and inter-byte timeouts
// raise a one-cycle o_err.
// Ports: i_clk, i_reset (async, active-low), bus (slave side of
// uart_alu_cmd_if: RX/TX strobes, ALU operands/result, tx start/data, err).
module uart_alu_cmd
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned OP_W         = DEF_OP_W,
  parameter int unsigned TIMEOUT_CLKS = 26040
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_alu_cmd_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              err_q, err_d;
  logic              op_ok_c;
  logic              cnt_en_c;
  logic              tc_c;

  assign op_ok_c = (bus.i_rx_data[DATA_W-1:OP_W] == '0) &&
                   is_valid_op(32'(bus.i_rx_data[OP_W-1:0]));

  assign cnt_en_c = (state_q == ST_A) || (state_q == ST_B);

  uart_alu_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (bus.i_rx_done),
    .i_en   (cnt_en_c),
    .o_tc_c (tc_c)
  );

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_OP;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_OP: begin
        if (bus.i_rx_done) begin
          if (op_ok_c) begin
            alu_op_d = bus.i_rx_data[OP_W-1:0];
            state_d  = ST_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // A byte arriving on the terminal-count cycle is still accepted
      ST_A: begin
        if (bus.i_rx_done) begin
          alu_a_d = bus.i_rx_data;
          state_d = ST_B;
        end else if (tc_c) begin
          err_d   = 1'b1;
          state_d = ST_OP;
        end
      end
      ST_B: begin
        if (bus.i_rx_done) begin
          alu_b_d = bus.i_rx_data;
          state_d = ST_CALC;
        end else if (tc_c) begin
          err_d   = 1'b1;
          state_d = ST_OP;
        end
      end
      ST_CALC: begin
        tx_data_d = bus.i_alu_result;
        state_d   = ST_SEND;
        err_d     = bus.i_rx_done;
      end
      // Registered start pulse appears as the FSM enters ST_WAIT_TX
      ST_SEND: begin
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
        err_d      = bus.i_rx_done;
      end
      ST_WAIT_TX: begin
        err_d = bus.i_rx_done;
        if (bus.i_tx_done) begin
          state_d = ST_OP;
        end
      end
      default: state_d = ST_OP;
    endcase
  end

  assign bus.o_alu_a    = alu_a_q;
  assign bus.o_alu_b    = alu_b_q;
  assign bus.o_alu_op   = alu_op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_uart_alu_cmd.sv
// Directed testbench for uart_alu_cmd with a behavioural ALU model.
module tb_uart_alu_cmd;
  import uart_alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 6;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   err_pulses;
  int   start_pulses;

  uart_alu_cmd_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  uart_alu_cmd #(
    .DATA_W      (DW),
    .OP_W        (OW),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (32'(bus.o_alu_op))
      OP_ADD:  bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
      OP_SUB:  bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
      OP_AND:  bus.i_alu_result = bus.o_alu_a & bus.o_alu_b;
      OP_OR:   bus.i_alu_result = bus.o_alu_a | bus.o_alu_b;
      OP_XOR:  bus.i_alu_result = bus.o_alu_a ^ bus.o_alu_b;
      OP_NOR:  bus.i_alu_result = ~(bus.o_alu_a | bus.o_alu_b);
      OP_SRL:  bus.i_alu_result = bus.o_alu_a >> bus.o_alu_b;
      OP_SRA:  bus.i_alu_result = DW'($signed(bus.o_alu_a) >>> bus.o_alu_b);
      default: bus.i_alu_result = '0;
    endcase
  end

  // Pulse counters, sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (bus.o_err === 1'b1) err_pulses++;
    if (bus.o_tx_start === 1'b1) start_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = b;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    send_byte(op);
    send_byte(a);
    send_byte(b);
  endtask

  // Cycles (negedges) until o_tx_start seen, -1 if never; optionally acks
  task automatic wait_tx_start(input bit ack, output int cyc, output logic [7:0] data);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    data = 8'h00;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
        data = bus.o_tx_data;
      end
    end
    if (ack) pulse_tx_done();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_alu_a !== 8'h00) begin errors++; $display("FAIL reset_a got=%h exp=00", bus.o_alu_a); end
    checks++; if (bus.o_alu_b !== 8'h00) begin errors++; $display("FAIL reset_b got=%h exp=00", bus.o_alu_b); end
    checks++; if (bus.o_alu_op !== 6'h00) begin errors++; $display("FAIL reset_op got=%h exp=00", bus.o_alu_op); end
    checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", bus.o_tx_data); end
    checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_txstart got=%b exp=0", bus.o_tx_start); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int cyc; logic [7:0] d; int s0, e0;
    s0 = start_pulses; e0 = err_pulses;
    send_cmd(8'h20, 8'h05, 8'h03);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", cyc); end
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL add_result got=%h exp=08", d); end
    checks++; if (bus.o_alu_op !== 6'h20) begin errors++; $display("FAIL add_op got=%h exp=20", bus.o_alu_op); end
    checks++; if (bus.o_alu_a !== 8'h05) begin errors++; $display("FAIL add_a got=%h exp=05", bus.o_alu_a); end
    checks++; if (bus.o_alu_b !== 8'h03) begin errors++; $display("FAIL add_b got=%h exp=03", bus.o_alu_b); end
    repeat (2) @(negedge clk);
    checks++; if (start_pulses - s0 !== 1) begin errors++; $display("FAIL add_start_count got=%0d exp=1", start_pulses - s0); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL add_err_count got=%0d exp=0", err_pulses - e0); end
  endtask

  task automatic test_shifts();
    int cyc; logic [7:0] d;
    send_cmd(8'h02, 8'h80, 8'h02);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL srl_result got=%h exp=20", d); end
    send_cmd(8'h03, 8'h80, 8'h02);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'hE0) begin errors++; $display("FAIL sra_result got=%h exp=e0", d); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL sra_latency got=%0d exp=2", cyc); end
  endtask

  task automatic test_bad_opcode();
    int cyc; logic [7:0] d; int e0, s0;
    e0 = err_pulses; s0 = start_pulses;
    send_byte(8'h21);
    @(negedge clk);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL badop_err got=%0d exp=1", err_pulses - e0); end
    send_byte(8'h60);
    @(negedge clk);
    checks++; if (err_pulses - e0 !== 2) begin errors++; $display("FAIL badop_upper_err got=%0d exp=2", err_pulses - e0); end
    send_cmd(8'h22, 8'h09, 8'h04);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL sub_result got=%h exp=05", d); end
    checks++; if (start_pulses - s0 !== 1) begin errors++; $display("FAIL badop_start_count got=%0d exp=1", start_pulses - s0); end
    checks++; if (err_pulses - e0 !== 2) begin errors++; $display("FAIL badop_total_err got=%0d exp=2", err_pulses - e0); end
  endtask

  task automatic test_timeout();
    int cyc; logic [7:0] d; int e0, s0;
    e0 = err_pulses; s0 = start_pulses;
    send_byte(8'h20);
    send_byte(8'h01);
    repeat (TO + 4) @(negedge clk);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_pulses - e0); end
    checks++; if (start_pulses - s0 !== 0) begin errors++; $display("FAIL timeout_start got=%0d exp=0", start_pulses - s0); end
    checks++; if (bus.o_alu_op !== 6'h20) begin errors++; $display("FAIL timeout_op got=%h exp=20", bus.o_alu_op); end
    checks++; if (bus.o_alu_a !== 8'h01) begin errors++; $display("FAIL timeout_a got=%h exp=01", bus.o_alu_a); end
    checks++; if (bus.o_alu_b !== 8'h04) begin errors++; $display("FAIL timeout_b got=%h exp=04", bus.o_alu_b); end
    send_cmd(8'h25, 8'h0F, 8'hF0);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL post_timeout_or got=%h exp=ff", d); end
  endtask

  // Operand A arrives on exactly the terminal-count cycle
  task automatic test_timeout_collision();
    int cyc; logic [7:0] d; int e0;
    e0 = err_pulses;
    send_byte(8'h26);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h5A);
    send_byte(8'hFF);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL collide_result got=%h exp=a5", d); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL collide_latency got=%0d exp=2", cyc); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL collide_err got=%0d exp=0", err_pulses - e0); end
  endtask

  task automatic test_rx_during_wait();
    int cyc; logic [7:0] d; int e0, s0;
    send_cmd(8'h20, 8'h10, 8'h20);
    wait_tx_start(1'b0, cyc, d);
    checks++; if (d !== 8'h30) begin errors++; $display("FAIL wait_add_result got=%h exp=30", d); end
    e0 = err_pulses; s0 = start_pulses;
    send_byte(8'h20);
    @(negedge clk);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL wait_rx_err got=%0d exp=1", err_pulses - e0); end
    checks++; if (bus.o_tx_data !== 8'h30) begin errors++; $display("FAIL wait_txdata got=%h exp=30", bus.o_tx_data); end
    pulse_tx_done();
    send_cmd(8'h27, 8'h0F, 8'h30);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'hC0) begin errors++; $display("FAIL wait_nor_result got=%h exp=c0", d); end
    checks++; if (start_pulses - s0 !== 1) begin errors++; $display("FAIL wait_start_count got=%0d exp=1", start_pulses - s0); end
  endtask

  task automatic test_tx_done_ignored();
    int cyc; logic [7:0] d; int e0;
    e0 = err_pulses;
    @(negedge clk);
    pulse_tx_done();
    send_byte(8'h20);
    pulse_tx_done();
    send_byte(8'h07);
    pulse_tx_done();
    send_byte(8'h08);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'h0F) begin errors++; $display("FAIL txdone_ign_result got=%h exp=0f", d); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL txdone_ign_err got=%0d exp=0", err_pulses - e0); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [7:0] d; int s0;
    send_byte(8'h24);
    send_byte(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_alu_a !== 8'h00) begin errors++; $display("FAIL midrst_a got=%h exp=00", bus.o_alu_a); end
    checks++; if (bus.o_alu_op !== 6'h00) begin errors++; $display("FAIL midrst_op got=%h exp=00", bus.o_alu_op); end
    checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL midrst_txdata got=%h exp=00", bus.o_tx_data); end
    repeat (3) @(negedge clk);
    s0 = start_pulses;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (start_pulses - s0 !== 0) begin errors++; $display("FAIL midrst_start got=%0d exp=0", start_pulses - s0); end
    send_cmd(8'h24, 8'hF0, 8'h3C);
    wait_tx_start(1'b1, cyc, d);
    checks++; if (d !== 8'h30) begin errors++; $display("FAIL midrst_and_result got=%h exp=30", d); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL midrst_latency got=%0d exp=2", cyc); end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    err_pulses    = 0;
    start_pulses  = 0;
    rst_n         = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_tx_done = 1'b0;
    test_reset();
    test_add();
    test_shifts();
    test_bad_opcode();
    test_timeout();
    test_timeout_collision();
    test_rx_during_wait();
    test_tx_done_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
